seq_detect_param: RTL

Parametrised serial bit-pattern detector with a registered match pulse, a selectable overlap mode, a sample-enable input and a saturating match counter. It is the next generation of the lab's fixed single-pattern serial detector. It sits directly on a one-bit serial stream, for example a UART receive bit stream or a test stimulus line, and feeds match events to downstream counters or FSMs.

---
 rtl/seq_detect_pkg.sv | 10 +
 rtl/seq_detect_param_sat_counter.sv | 24 ++
 rtl/seq_detect_param.sv | 60 ++++++
 3 files changed

// File: rtl/seq_detect_pkg.sv
// Shared constants and helpers for the serial pattern detector family.
package seq_detect_pkg;
  localparam logic OVL_ON  = 1'b1;
  localparam logic OVL_OFF = 1'b0;

  // fill must hold 0..pat_w inclusive
  function automatic int fill_w(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction
endpackage

// File: rtl/seq_detect_param_sat_counter.sv
// Saturating up-counter with a registered all-ones flag and synchronous clear.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q,
  output logic         sat
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q   <= '0;
      sat <= 1'b0;
    end else if (clr) begin
      q   <= '0;
      sat <= 1'b0;
    end else if (inc && !sat) begin
      q   <= q + 1'b1;
      sat <= (q + 1'b1) == {W{1'b1}};
    end
  end
endmodule

// File: rtl/seq_detect_param.sv
// Parametrised serial pattern detector: history shift register, fill tracking,
// comparator, registered match pulse and saturating match counter.
module seq_detect_param
  import seq_detect_pkg::*;
#(
  parameter int             PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
  parameter int             CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             in,
  input  logic             overlap,
  output logic             out,
  output logic [CNT_W-1:0] count,
  output logic             sat
);
  localparam int FW = fill_w(PAT_W);
  localparam logic [FW-1:0] FULL = FW'(PAT_W);

  logic [PAT_W-1:0] hist, hist_nxt;
  logic [FW-1:0]    fill, fill_inc;
  logic             match;

  always_comb begin
    hist_nxt = {hist[PAT_W-2:0], in};
    fill_inc = (fill == FULL) ? FULL : fill + 1'b1;
    match    = en && (fill_inc == FULL) && (hist_nxt == PATTERN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist <= '0;
      fill <= '0;
      out  <= 1'b0;
    end else if (clr) begin
      hist <= '0;
      fill <= '0;
      out  <= 1'b0;
    end else begin
      out <= match;
      if (en) begin
        hist <= hist_nxt;
        // non-overlap: keep the bits but mark them all stale
        fill <= (match && overlap == OVL_OFF) ? '0 : fill_inc;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (match),
    .q   (count),
    .sat (sat)
  );
endmodule
